// File: rtl/rv_pkg.sv
// Shared definitions for the fetch-side branch predictor: counter encodings,
// the table entry layout and the sequential PC step.
package rv_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [31:0] PC_STEP = 32'd4;

    // The tag field is sized for the widest possible tag.
    // Narrower tags are stored zero-extended.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } bht_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating counter.
// Ports: ctr (current value), inc (1 = step up, 0 = step down), ctr_next (result).
module sat_counter2
    import rv_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        unique case (1'b1)
            inc && (ctr != CTR_ST):  ctr_next = ctr + 2'd1;
            !inc && (ctr != CTR_SNT): ctr_next = ctr - 2'd1;
            default:                 ctr_next = ctr;
        endcase
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table with tag, target and 2-bit counter,
// trained by EX-stage branch outcomes, plus a registered redirect and statistics.
// Ports:
//   clk, rst (sync, active high)
//   pc_if -> pred_hit, pred_taken, pred_target (combinational lookup)
//   upd_* (resolved branch from EX) -> mispredict, redirect_pc (registered)
//   branch_cnt, mispredict_cnt (free-running, wrap at 2^32)
module branch_predictor_bht
    import rv_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 32 - IDX_W - 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_if,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
);

    bht_entry_t bht [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    bht_entry_t       lk_ent;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    bht_entry_t       up_ent;
    bht_entry_t       up_new;
    logic             up_hit;
    logic [1:0]       ctr_nxt;
    logic [31:0]      correct_pc;
    logic             wrong;

    // Address bits [1:0] never participate; the pipe's prediction direction
    // is informational only because the target comparison subsumes it.
    logic unused_ok;
    assign unused_ok = &{1'b0, pc_if[1:0], upd_pc[1:0], upd_pred_taken};

    // Lookup: reads pre-update contents, no bypass from the write port.
    assign lk_idx = pc_if[IDX_W+1:2];
    assign lk_tag = pc_if[31:IDX_W+2];
    assign lk_ent = bht[lk_idx];

    assign pred_hit    = lk_ent.valid &&
                         (lk_ent.tag == {{(32-TAG_W){1'b0}}, lk_tag});
    assign pred_taken  = pred_hit && lk_ent.ctr[1];
    assign pred_target = pred_taken ? lk_ent.target : pc_if + PC_STEP;

    // Update path
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];
    assign up_ent = bht[up_idx];
    assign up_hit = up_ent.valid &&
                    (up_ent.tag == {{(32-TAG_W){1'b0}}, up_tag});

    sat_counter2 u_ctr (
        .ctr      (up_ent.ctr),
        .inc      (upd_taken),
        .ctr_next (ctr_nxt)
    );

    always_comb begin
        up_new = up_ent;
        if (!up_hit) begin
            up_new.valid  = 1'b1;
            up_new.tag    = {{(32-TAG_W){1'b0}}, up_tag};
            up_new.target = upd_target;
            up_new.ctr    = upd_taken ? CTR_WT : CTR_WNT;
        end else begin
            up_new.ctr = ctr_nxt;
            if (upd_taken) begin
                up_new.target = upd_target;
            end
        end
    end

    assign correct_pc = upd_taken ? upd_target : upd_pc + PC_STEP;
    assign wrong      = upd_valid && (upd_pred_target != correct_pc);

    // Only valid bits are reset; other fields are ignored while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i].valid <= 1'b0;
            end
        end else if (upd_valid) begin
            bht[up_idx] <= up_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict     <= 1'b0;
            redirect_pc    <= 32'd0;
            branch_cnt     <= 32'd0;
            mispredict_cnt <= 32'd0;
        end else begin
            mispredict <= wrong;
            if (upd_valid) begin
                redirect_pc <= correct_pc;
                branch_cnt  <= branch_cnt + 32'd1;
            end
            if (wrong) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: a behavioural table model
// feeds a scoreboard of expected registered outputs, popped after each edge.
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_if;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predictor_bht dut (
        .clk             (clk),
        .rst             (rst),
        .pc_if           (pc_if),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .branch_cnt      (branch_cnt),
        .mispredict_cnt  (mispredict_cnt)
    );

    typedef struct {
        logic        mp;
        logic [31:0] rd;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb [$];

    // Reference model
    bit          m_v   [64];
    logic [23:0] m_tag [64];
    logic [31:0] m_tgt [64];
    logic [1:0]  m_ctr [64];
    logic [31:0] m_rd, m_bc, m_mc;

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[pc[7:2]] && (m_tag[pc[7:2]] == pc[31:8]);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_v[i] = 0;
        m_rd = 0;
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic m_train(input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt);
        int i;
        i = int'(pc[7:2]);
        if (!m_hit(pc)) begin
            m_v[i]   = 1;
            m_tag[i] = pc[31:8];
            m_tgt[i] = tgt;
            m_ctr[i] = tk ? 2'b10 : 2'b01;
        end else if (tk) begin
            if (m_ctr[i] != 2'b11) m_ctr[i] = m_ctr[i] + 2'd1;
            m_tgt[i] = tgt;
        end else begin
            if (m_ctr[i] != 2'b00) m_ctr[i] = m_ctr[i] - 2'd1;
        end
    endtask

    // Compare the combinational lookup for pc against the model.
    task automatic lookup(input logic [31:0] pc, input string name);
        logic        eh, et;
        logic [31:0] eg;
        pc_if = pc;
        #1;
        eh = m_hit(pc);
        et = eh && m_ctr[pc[7:2]][1];
        eg = et ? m_tgt[pc[7:2]] : pc + 32'd4;
        checks++;
        if (pred_hit !== eh || pred_taken !== et || pred_target !== eg) begin
            errs++;
            $display("FAIL %s pc=%h: hit/taken/target got %b/%b/%h want %b/%b/%h",
                     name, pc, pred_hit, pred_taken, pred_target, eh, et, eg);
        end
    endtask

    // One clock edge, then pop and compare the scoreboard.
    task automatic step(input string name);
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errs++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if (mispredict !== e.mp || redirect_pc !== e.rd ||
                branch_cnt !== e.bc || mispredict_cnt !== e.mc) begin
                errs++;
                $display("FAIL %s: mp/rd/bc/mc got %b/%h/%0d/%0d want %b/%h/%0d/%0d",
                         name, mispredict, redirect_pc, branch_cnt, mispredict_cnt,
                         e.mp, e.rd, e.bc, e.mc);
            end
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic [31:0] ptgt,
                       input string name);
        logic [31:0] cpc;
        logic        mp;
        @(negedge clk);
        upd_valid       = 1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_target = ptgt;
        upd_pred_taken  = (ptgt != pc + 32'd4);
        // Lookup before the edge must see pre-update contents.
        lookup(pc_if, {name, "_pre"});
        cpc = tk ? tgt : pc + 32'd4;
        mp  = (ptgt != cpc);
        m_bc++;
        if (mp) m_mc++;
        m_rd = cpc;
        sb.push_back('{mp, m_rd, m_bc, m_mc});
        step(name);
        m_train(pc, tk, tgt);
    endtask

    task automatic idle(input string name);
        @(negedge clk);
        upd_valid = 0;
        sb.push_back('{1'b0, m_rd, m_bc, m_mc});
        step(name);
    endtask

    task automatic test_reset();
        rst       = 1;
        upd_valid = 0;
        upd_pc    = 0;
        upd_taken = 0;
        upd_target = 0;
        upd_pred_taken = 0;
        upd_pred_target = 0;
        pc_if     = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        checks++;
        if (mispredict !== 1'b0 || redirect_pc !== 32'd0 ||
            branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0) begin
            errs++;
            $display("FAIL reset_regs: got %b/%h/%0d/%0d want 0/0/0/0",
                     mispredict, redirect_pc, branch_cnt, mispredict_cnt);
        end
        checks++;
        if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            errs++;
            $display("FAIL reset_lookup: got %b/%b/%h want 0/0/00000104",
                     pred_hit, pred_taken, pred_target);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_alloc();
        upd(32'h100, 1, 32'h200, 32'h104, "alloc");
        idle("alloc_idle");
        pc_if = 32'h100;
        #1;
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            errs++;
            $display("FAIL alloc_hit: got %b/%b/%h want 1/1/00000200",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_saturate();
        repeat (3) upd(32'h100, 1, 32'h200, 32'h200, "sat_t");
        upd(32'h100, 0, 32'h200, 32'h200, "sat_nt1");
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h104) begin
            errs++;
            $display("FAIL sat_nt1_redirect: got %b/%h want 1/00000104",
                     mispredict, redirect_pc);
        end
        lookup(32'h100, "sat_after_nt1");
        upd(32'h100, 0, 32'h200, 32'h104, "sat_nt2");
        lookup(32'h100, "sat_after_nt2");
        idle("sat_idle");
    endtask

    task automatic test_alias();
        upd(32'h500, 0, 32'h900, 32'h504, "alias");
        lookup(32'h100, "alias_old");
        lookup(32'h500, "alias_new");
        idle("alias_idle");
    endtask

    task automatic test_back_to_back();
        pc_if = 32'h40;
        for (int i = 0; i < 6; i++)
            upd(32'h40, i[0], 32'h80, 32'h44, "b2b_alt");
        lookup(32'h40, "b2b_alt_lk");
        for (int i = 0; i < 20; i++) begin
            logic [31:0] p, t, g;
            logic        k;
            p = 32'h1000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 3) << 2);
            k = 1'($urandom_range(0, 1));
            t = 32'h3000 + 32'($urandom_range(0, 1) * 16);
            g = $urandom_range(0, 1) ? t : p + 32'd4;
            pc_if = p;
            upd(p, k, t, g, "b2b_rand");
        end
        idle("b2b_idle1");
        idle("b2b_idle2");
        for (int i = 0; i < 4; i++)
            lookup(32'h1000 + 32'(i << 8) + 32'(i << 2), "b2b_lk");
    endtask

    task automatic test_wrap();
        upd(32'hFFFF_FFFC, 0, 32'h10, 32'h0, "wrap_nt");
        upd(32'hFFFF_FFFC, 1, 32'h10, 32'h0, "wrap_t");
        lookup(32'hFFFF_FFFF, "wrap_lowbits");
        upd(32'h0000_0703, 1, 32'h20, 32'h20, "predtaken_ignored");
        lookup(32'h0000_0700, "lowbits_upd");
        idle("wrap_idle");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst             = 1;
        upd_valid       = 1;
        upd_pc          = 32'h100;
        upd_taken       = 1;
        upd_target      = 32'h200;
        upd_pred_target = 32'h104;
        @(posedge clk);
        #1;
        m_reset();
        checks++;
        if (mispredict !== 1'b0 || branch_cnt !== 32'd0 ||
            mispredict_cnt !== 32'd0 || redirect_pc !== 32'd0) begin
            errs++;
            $display("FAIL reset_mid: got %b/%h/%0d/%0d want 0/0/0/0",
                     mispredict, redirect_pc, branch_cnt, mispredict_cnt);
        end
        @(negedge clk);
        rst       = 0;
        upd_valid = 0;
        lookup(32'h100, "reset_mid_lk");
        idle("reset_mid_idle");
        lookup(32'h100, "reset_mid_lk2");
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_saturate();
        test_alias();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
